// File: rtl/micro_sequencer.sv
// Two-phase (ISSUE/EXEC) microprogram sequencer with range-checked branch targets.
// Define MICRO_SEQUENCER_USTACK_EN to add a 2-entry microsubroutine return stack (CALL/RETURN).
module micro_sequencer #(
  parameter logic [4:0] FETCH_ADDR = 5'd1,
  parameter logic [4:0] DISP_BASE  = 5'd8,
  parameter logic [4:0] MAX_ADDR   = 5'd24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [28:0] cwrd,
  input  logic [3:0]  opcode,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_n,
  input  logic        stall,
  output logic [4:0]  addr,
  output logic        cw_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {ISSUE, EXEC, HALT} state_t;

  state_t     state, state_nx;
  logic [4:0] addr_nx;
  logic       err_nx;

  logic [4:0] nxt;
  logic [1:0] mode, csel;
  logic       cond;
  logic [5:0] seq_addr;
  logic [5:0] target;
  logic       is_call, is_ret, stk_fault;
  logic       do_push, do_pop;
  logic       unused_cwrd;

  assign nxt         = cwrd[4:0];
  assign mode        = cwrd[6:5];
  assign csel        = cwrd[8:7];
  assign unused_cwrd = ^cwrd[28:9];

  // Six bits so that addr+1 and dispatch overflow stay visible to the range check.
  assign seq_addr = {1'b0, addr} + 6'd1;

  always_comb begin
    case (csel)
      2'b00:   cond = 1'b1;
      2'b01:   cond = flag_z;
      2'b10:   cond = flag_c;
      default: cond = flag_n;
    endcase
  end

`ifdef MICRO_SEQUENCER_USTACK_EN
  logic [1:0][5:0] stk;
  logic [1:0]      sp;
  logic [5:0]      stk_top;

  assign is_call   = (mode == 2'b11) && (csel == 2'b11);
  assign is_ret    = (mode == 2'b00) && (csel == 2'b11);
  assign stk_top   = (sp == 2'd2) ? stk[1] : stk[0];
  assign stk_fault = (is_call && sp == 2'd2) || (is_ret && sp == 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      stk <= '0;
      sp  <= 2'd0;
    end else if (do_push) begin
      stk[sp[0]] <= seq_addr;
      sp         <= sp + 2'd1;
    end else if (do_pop) begin
      sp <= sp - 2'd1;
    end
  end
`else
  logic [5:0] stk_top;
  assign is_call   = 1'b0;
  assign is_ret    = 1'b0;
  assign stk_top   = 6'd0;
  assign stk_fault = 1'b0;
`endif

  always_comb begin
    case (mode)
      2'b00:   target = is_ret ? stk_top : {1'b0, FETCH_ADDR};
      2'b01:   target = cond ? {1'b0, nxt} : seq_addr;
      2'b10:   target = {1'b0, DISP_BASE} + {2'b00, opcode};
      default: target = {1'b0, nxt};
    endcase
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    err_nx   = err;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    case (state)
      ISSUE: if (!stall) state_nx = EXEC;
      // Flags and cwrd are only consumed on the un-stalled EXEC edge.
      EXEC: if (!stall) begin
        if (target > {1'b0, MAX_ADDR} || stk_fault) begin
          err_nx   = 1'b1;
          state_nx = HALT;
        end else begin
          addr_nx  = target[4:0];
          state_nx = ISSUE;
          do_push  = is_call;
          do_pop   = is_ret;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ISSUE;
      addr  <= FETCH_ADDR;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      err   <= err_nx;
    end
  end

  assign cw_valid = (state == EXEC);
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed scoreboard bench for micro_sequencer; a second instance with DISP_BASE=20
// exercises dispatch overflow.
module tb_micro_sequencer;
  logic        clk, reset, stall, flag_z, flag_c, flag_n;
  logic [28:0] cwrd;
  logic [3:0]  opcode;
  logic [4:0]  addr, addr2;
  logic        cw_valid, halted, err, cw_valid2, halted2, err2;

  int checks = 0;
  int errors = 0;
  logic [4:0] cur;

  typedef struct {
    string      tag;
    logic [4:0] addr;
    logic       cv;
    logic       err;
    logic       halted;
  } exp_t;
  exp_t sbq[$];

  micro_sequencer u_dut (
    .clk(clk), .reset(reset), .cwrd(cwrd), .opcode(opcode),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .stall(stall),
    .addr(addr), .cw_valid(cw_valid), .halted(halted), .err(err)
  );

  micro_sequencer #(.DISP_BASE(5'd20)) u_d20 (
    .clk(clk), .reset(reset), .cwrd(cwrd), .opcode(opcode),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .stall(stall),
    .addr(addr2), .cw_valid(cw_valid2), .halted(halted2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [4:0] a, input logic cv,
                            input logic e, input logic h);
    exp_t x;
    x.tag = tag; x.addr = a; x.cv = cv; x.err = e; x.halted = h;
    sbq.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    x = sbq.pop_front();
    chk({x.tag, "_addr"}, {3'b0, addr},   {3'b0, x.addr});
    chk({x.tag, "_cv"},   {7'b0, cw_valid}, {7'b0, x.cv});
    chk({x.tag, "_err"},  {7'b0, err},    {7'b0, x.err});
    chk({x.tag, "_halt"}, {7'b0, halted}, {7'b0, x.halted});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full microinstruction from ISSUE: EXEC phase, then the target edge.
  task automatic exec_instr(input string tag, input logic [1:0] m, input logic [1:0] cs,
                            input logic [4:0] nx, input logic [3:0] op,
                            input logic fz, input logic fc, input logic fn,
                            input logic [4:0] exp_a, input logic exp_e, input logic exp_h);
    cwrd = {20'd0, cs, m, nx}; opcode = op;
    flag_z = fz; flag_c = fc; flag_n = fn; stall = 1'b0;
    expect_out({tag, "_exec"}, cur, 1'b1, 1'b0, 1'b0);
    tick(); check_out();
    expect_out(tag, exp_a, 1'b0, exp_e, exp_h);
    tick(); check_out();
    cur = exp_a;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; cwrd = '0; opcode = '0;
    flag_z = 1'b0; flag_c = 1'b0; flag_n = 1'b0;
    expect_out("reset", 5'd1, 1'b0, 1'b0, 1'b0);
    tick(); check_out();
    reset = 1'b0; cur = 5'd1;

    exec_instr("jmp7",  2'b11, 2'b00, 5'd7,  4'h0, 0, 0, 0, 5'd7,  0, 0);
    exec_instr("jmp9",  2'b11, 2'b00, 5'd9,  4'h0, 0, 0, 0, 5'd9,  0, 0);
    exec_instr("bz_t",  2'b01, 2'b01, 5'd12, 4'h0, 1, 0, 0, 5'd12, 0, 0);
    exec_instr("jmp9b", 2'b11, 2'b00, 5'd9,  4'h0, 0, 0, 0, 5'd9,  0, 0);
    exec_instr("bz_f",  2'b01, 2'b01, 5'd12, 4'h0, 0, 1, 1, 5'd10, 0, 0);
    exec_instr("bc_t",  2'b01, 2'b10, 5'd17, 4'h0, 0, 1, 0, 5'd17, 0, 0);
    exec_instr("bn_f",  2'b01, 2'b11, 5'd3,  4'h0, 1, 1, 0, 5'd18, 0, 0);
    exec_instr("fetch", 2'b00, 2'b00, 5'd20, 4'h0, 0, 0, 0, 5'd1,  0, 0);
    exec_instr("btrue", 2'b01, 2'b00, 5'd5,  4'h0, 0, 0, 0, 5'd5,  0, 0);

    // Stall in ISSUE, then three stalled EXEC cycles with a flag that changes only at release.
    stall = 1'b1; cwrd = {20'd0, 2'b01, 2'b01, 5'd20}; flag_z = 1'b0;
    expect_out("stall_issue", 5'd5, 1'b0, 1'b0, 1'b0);
    tick(); check_out();
    stall = 1'b0;
    expect_out("stall_enter", 5'd5, 1'b1, 1'b0, 1'b0);
    tick(); check_out();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out("stall_exec", 5'd5, 1'b1, 1'b0, 1'b0);
      tick(); check_out();
    end
    flag_z = 1'b1; stall = 1'b0;
    expect_out("stall_rel", 5'd20, 1'b0, 1'b0, 1'b0);
    tick(); check_out();
    cur = 5'd20;

    exec_instr("disp3", 2'b10, 2'b00, 5'd0, 4'h3, 0, 0, 0, 5'd11, 0, 0);
    chk("d20_disp3_addr", {3'b0, addr2}, 8'd23);
    exec_instr("disp6", 2'b10, 2'b00, 5'd0, 4'h6, 0, 0, 0, 5'd14, 0, 0);
    chk("d20_ovf_addr", {3'b0, addr2}, 8'd23);
    chk("d20_ovf_err",  {7'b0, err2}, 8'd1);
    chk("d20_ovf_halt", {7'b0, halted2}, 8'd1);

    exec_instr("jmp3", 2'b11, 2'b00, 5'd3, 4'h0, 0, 0, 0, 5'd3, 0, 0);
    chk("d20_hold_addr", {3'b0, addr2}, 8'd23);
    chk("d20_hold_cv",   {7'b0, cw_valid2}, 8'd0);

    exec_instr("jmp24", 2'b11, 2'b00, 5'd24, 4'h0, 0, 0, 0, 5'd24, 0, 0);
    exec_instr("seqovf", 2'b01, 2'b01, 5'd2, 4'h0, 0, 0, 0, 5'd24, 1, 1);
    cwrd = {20'd0, 2'b00, 2'b11, 5'd5};
    expect_out("halt_hold", 5'd24, 1'b0, 1'b1, 1'b1);
    tick(); check_out();

    reset = 1'b1; stall = 1'b1;
    expect_out("rst_halt", 5'd1, 1'b0, 1'b0, 1'b0);
    tick(); check_out();
    chk("d20_rst_err", {7'b0, err2}, 8'd0);
    reset = 1'b0; stall = 1'b0; cwrd = {20'd0, 2'b00, 2'b11, 5'd9};
    expect_out("pre_rst_exec", 5'd1, 1'b1, 1'b0, 1'b0);
    tick(); check_out();
    reset = 1'b1;
    expect_out("rst_exec", 5'd1, 1'b0, 1'b0, 1'b0);
    tick(); check_out();
    reset = 1'b0; cur = 5'd1;

`ifdef MICRO_SEQUENCER_USTACK_EN
    exec_instr("s_jmp3", 2'b11, 2'b00, 5'd3,  4'h0, 0, 0, 0, 5'd3,  0, 0);
    exec_instr("call15", 2'b11, 2'b11, 5'd15, 4'h0, 0, 0, 0, 5'd15, 0, 0);
    exec_instr("ret",    2'b00, 2'b11, 5'd0,  4'h0, 0, 0, 0, 5'd4,  0, 0);
    exec_instr("callA",  2'b11, 2'b11, 5'd10, 4'h0, 0, 0, 0, 5'd10, 0, 0);
    exec_instr("callB",  2'b11, 2'b11, 5'd11, 4'h0, 0, 0, 0, 5'd11, 0, 0);
    exec_instr("callC",  2'b11, 2'b11, 5'd12, 4'h0, 0, 0, 0, 5'd11, 1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; cur = 5'd1;
    exec_instr("ret_empty", 2'b00, 2'b11, 5'd0, 4'h0, 0, 0, 0, 5'd1, 1, 1);
`else
    exec_instr("jmp_c11",   2'b11, 2'b11, 5'd15, 4'h0, 0, 0, 0, 5'd15, 0, 0);
    exec_instr("fetch_c11", 2'b00, 2'b11, 5'd20, 4'h0, 0, 0, 0, 5'd1,  0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
